// File: rtl/quant_sweep_ctrl.sv
// rtl/quant_sweep_ctrl.sv - truncating quantizer sweep sequencer (16/8/4/3/2/1 bits); QSWEEP_MAXERR_EN adds per-resolution max error
module quant_sweep_ctrl #(
  parameter int NUM_SAMPLES = 16,
  parameter int ACC_W       = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              q_valid,
  output logic [4:0]        q_res,
  output logic [31:0]       q_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_res,
  output logic [ACC_W-1:0]  out_err,
  output logic [31:0]       out_max,
  output logic              done
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    QUANT  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [2:0]        idx;
  logic [2:0]        idx_nx;
  logic [31:0]       sample;
  logic [31:0]       sample_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc [6];

  logic              blk_clear;
  logic              load_fire;
  logic              last_idx;
  logic              blk_done;
  logic [31:0]       err_cur;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W-1:0]  acc_sat;

  // Resolution in bits for each sweep step.
  function automatic logic [4:0] res_of(input logic [2:0] i);
    case (i)
      3'd0:    res_of = 5'd16;
      3'd1:    res_of = 5'd8;
      3'd2:    res_of = 5'd4;
      3'd3:    res_of = 5'd3;
      3'd4:    res_of = 5'd2;
      default: res_of = 5'd1;
    endcase
  endfunction

  // Bits discarded by truncation at each sweep step; the error is the sample under this mask.
  function automatic logic [31:0] err_mask(input logic [2:0] i);
    case (i)
      3'd0:    err_mask = 32'h0000_FFFF;
      3'd1:    err_mask = 32'h00FF_FFFF;
      3'd2:    err_mask = 32'h0FFF_FFFF;
      3'd3:    err_mask = 32'h1FFF_FFFF;
      3'd4:    err_mask = 32'h3FFF_FFFF;
      default: err_mask = 32'h7FFF_FFFF;
    endcase
  endfunction

  assign blk_clear = (state == IDLE) && start;
  assign load_fire = (state == LOAD) && in_valid;
  assign last_idx  = (idx == 3'd5);
  assign blk_done  = (cnt == CNT_W'(NUM_SAMPLES));
  assign err_cur   = sample & err_mask(idx);
  assign acc_sum   = {1'b0, acc[idx]} + {{(ACC_W + 1 - 32){1'b0}}, err_cur};
  assign acc_sat   = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic, sweep index and sample capture.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    sample_nx = sample;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          state_nx  = QUANT;
          idx_nx    = 3'd0;
          sample_nx = in_data;
        end
      end
      QUANT: begin
        if (last_idx) begin
          idx_nx   = 3'd0;
          state_nx = blk_done ? REPORT : LOAD;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      REPORT: begin
        if (out_ready) begin
          if (last_idx) begin
            idx_nx   = 3'd0;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // Sweep index and captured sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 3'd0;
      sample <= 32'd0;
    end else begin
      idx    <= idx_nx;
      sample <= sample_nx;
    end
  end

  // Sample counter: cleared when a block starts, counts accepted samples.
  always_ff @(posedge clk) begin
    if (rst || blk_clear) begin
      cnt <= '0;
    end else if (load_fire) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Saturating error accumulators, one per resolution.
  always_ff @(posedge clk) begin
    if (rst || blk_clear) begin
      for (int i = 0; i < 6; i++) begin
        acc[i] <= '0;
      end
    end else if (state == QUANT) begin
      acc[idx] <= acc_sat;
    end
  end

`ifdef QSWEEP_MAXERR_EN
  logic [31:0] max_err [6];

  // Largest single-sample error seen per resolution in this block.
  always_ff @(posedge clk) begin
    if (rst || blk_clear) begin
      for (int i = 0; i < 6; i++) begin
        max_err[i] <= 32'd0;
      end
    end else if ((state == QUANT) && (err_cur > max_err[idx])) begin
      max_err[idx] <= err_cur;
    end
  end

  // Registered max-error result; only the REPORT entry/advance edges change the selected entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_max <= 32'd0;
    end else begin
      out_max <= (state_nx == REPORT) ? max_err[idx_nx] : 32'd0;
    end
  end
`else
  assign out_max = 32'd0;
`endif

  // Registered monitor and result outputs, aligned with the state they describe.
  // The accumulator selected on REPORT entry (index 0) is never the one updated on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid   <= 1'b0;
      q_res     <= 5'd0;
      q_data    <= 32'd0;
      out_valid <= 1'b0;
      out_res   <= 5'd0;
      out_err   <= '0;
      done      <= 1'b0;
    end else begin
      q_valid   <= (state_nx == QUANT);
      q_res     <= (state_nx == QUANT) ? res_of(idx_nx) : 5'd0;
      q_data    <= (state_nx == QUANT) ? (sample_nx & ~err_mask(idx_nx)) : 32'd0;
      out_valid <= (state_nx == REPORT);
      out_res   <= (state_nx == REPORT) ? res_of(idx_nx) : 5'd0;
      out_err   <= (state_nx == REPORT) ? acc[idx_nx] : '0;
      done      <= (state == REPORT) && out_ready && last_idx;
    end
  end

endmodule

// File: tb/tb_quant_sweep_ctrl.sv
// tb/tb_quant_sweep_ctrl.sv - self-checking bench for quant_sweep_ctrl with a behavioural sweep model
module tb_quant_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic [1:0]  sel;

  logic [2:0]  v_busy, v_in_ready, v_q_valid, v_out_valid, v_done;
  logic [4:0]  v_q_res [3];
  logic [4:0]  v_out_res [3];
  logic [31:0] v_q_data [3];
  logic [31:0] v_out_max [3];
  logic [39:0] err0;
  logic [31:0] err1;
  logic [39:0] err2;

  logic        m_busy, m_in_ready, m_q_valid, m_out_valid, m_done;
  logic [4:0]  m_q_res, m_out_res;
  logic [31:0] m_q_data, m_out_max;
  logic [63:0] m_err;

  logic [31:0] samp [16];
  int total = 0;
  int bad   = 0;

  quant_sweep_ctrl #(.NUM_SAMPLES(16), .ACC_W(40)) u_dut0 (
    .clk(clk), .rst(rst), .start(start && (sel == 2'd0)), .busy(v_busy[0]),
    .in_valid(in_valid), .in_ready(v_in_ready[0]), .in_data(in_data),
    .q_valid(v_q_valid[0]), .q_res(v_q_res[0]), .q_data(v_q_data[0]),
    .out_valid(v_out_valid[0]), .out_ready(out_ready), .out_res(v_out_res[0]),
    .out_err(err0), .out_max(v_out_max[0]), .done(v_done[0]));

  quant_sweep_ctrl #(.NUM_SAMPLES(4), .ACC_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .start(start && (sel == 2'd1)), .busy(v_busy[1]),
    .in_valid(in_valid), .in_ready(v_in_ready[1]), .in_data(in_data),
    .q_valid(v_q_valid[1]), .q_res(v_q_res[1]), .q_data(v_q_data[1]),
    .out_valid(v_out_valid[1]), .out_ready(out_ready), .out_res(v_out_res[1]),
    .out_err(err1), .out_max(v_out_max[1]), .done(v_done[1]));

  quant_sweep_ctrl #(.NUM_SAMPLES(1), .ACC_W(40)) u_dut2 (
    .clk(clk), .rst(rst), .start(start && (sel == 2'd2)), .busy(v_busy[2]),
    .in_valid(in_valid), .in_ready(v_in_ready[2]), .in_data(in_data),
    .q_valid(v_q_valid[2]), .q_res(v_q_res[2]), .q_data(v_q_data[2]),
    .out_valid(v_out_valid[2]), .out_ready(out_ready), .out_res(v_out_res[2]),
    .out_err(err2), .out_max(v_out_max[2]), .done(v_done[2]));

  // Present the selected instance's outputs.
  always_comb begin
    m_busy      = v_busy[sel];
    m_in_ready  = v_in_ready[sel];
    m_q_valid   = v_q_valid[sel];
    m_out_valid = v_out_valid[sel];
    m_done      = v_done[sel];
    m_q_res     = v_q_res[sel];
    m_q_data    = v_q_data[sel];
    m_out_res   = v_out_res[sel];
    m_out_max   = v_out_max[sel];
    case (sel)
      2'd0:    m_err = 64'(err0);
      2'd1:    m_err = 64'(err1);
      default: m_err = 64'(err2);
    endcase
  end

  function automatic int nsamp(input logic [1:0] s);
    return (s == 2'd0) ? 16 : (s == 2'd1) ? 4 : 1;
  endfunction

  function automatic int accw(input logic [1:0] s);
    return (s == 2'd1) ? 32 : 40;
  endfunction

  function automatic logic [4:0] res_m(input int k);
    case (k)
      0:       return 5'd16;
      1:       return 5'd8;
      2:       return 5'd4;
      3:       return 5'd3;
      4:       return 5'd2;
      default: return 5'd1;
    endcase
  endfunction

  // Runs one block on instance s and checks every QUANT and REPORT cycle against the model.
  task automatic run_block(input logic [1:0] s, input bit gaps, input bit toggle,
                           input bit noise, input bit skip_start, input bit chain);
    logic [63:0] acc_m [6];
    logic [63:0] max_m [6];
    logic [63:0] lim, y, e, exp_max;
    logic [31:0] qd;
    logic [4:0]  r;
    int          n, idx, cyc;
    int unsigned g;
    bit          rdy;
    n   = nsamp(s);
    lim = (64'd1 << accw(s)) - 64'd1;
    sel = s;
    for (int k = 0; k < 6; k++) begin
      acc_m[k] = 64'd0;
      max_m[k] = 64'd0;
    end
    if (!skip_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int si = 0; si < n; si++) begin
      in_valid = 1'b0;
      start    = 1'b0;
      g = gaps ? $urandom_range(0, 3) : 0;
      repeat (g) begin
        @(negedge clk);
        total++;
        if (m_in_ready !== 1'b1 || m_busy !== 1'b1 || m_q_valid !== 1'b0) begin
          bad++;
          $display("FAIL load_wait got in_ready=%b busy=%b q_valid=%b want 1 1 0", m_in_ready, m_busy, m_q_valid);
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = samp[si];
      @(negedge clk);
      total++;
      if (m_in_ready !== 1'b1 || m_busy !== 1'b1 || m_q_valid !== 1'b0) begin
        bad++;
        $display("FAIL load got in_ready=%b busy=%b q_valid=%b want 1 1 0", m_in_ready, m_busy, m_q_valid);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
        if (noise) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = $urandom;
          start    = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
        y  = 64'(samp[si]);
        r  = res_m(k);
        e  = y % (64'd1 << (32 - r));
        qd = 32'(y - e);
        @(negedge clk);
        total++;
        if (m_q_valid !== 1'b1 || m_q_res !== r || m_q_data !== qd || m_in_ready !== 1'b0 || m_out_valid !== 1'b0) begin
          bad++;
          $display("FAIL quant s%0d k%0d got v=%b res=%0d data=%h rdy=%b ov=%b want res=%0d data=%h",
                   si, k, m_q_valid, m_q_res, m_q_data, m_in_ready, m_out_valid, r, qd);
        end
        acc_m[k] = (acc_m[k] + e > lim) ? lim : acc_m[k] + e;
        if (e > max_m[k]) max_m[k] = e;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 100) begin
      @(negedge clk);
`ifdef QSWEEP_MAXERR_EN
      exp_max = max_m[idx];
`else
      exp_max = 64'd0;
`endif
      total++;
      if (m_out_valid !== 1'b1 || m_out_res !== res_m(idx) || m_err !== acc_m[idx] ||
          64'(m_out_max) !== exp_max || m_done !== 1'b0 || m_busy !== 1'b1) begin
        bad++;
        $display("FAIL report idx=%0d got v=%b res=%0d err=%h max=%h done=%b want res=%0d err=%h max=%h",
                 idx, m_out_valid, m_out_res, m_err, m_out_max, m_done, res_m(idx), acc_m[idx], exp_max);
      end
      rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (idx != 6) begin
      bad++;
      $display("FAIL report_count got %0d want 6", idx);
    end
    if (chain) start = 1'b1;
    @(negedge clk);
    total++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL done got done=%b busy=%b out_valid=%b want 1 0 0", m_done, m_busy, m_out_valid);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (m_done !== 1'b0 || m_in_ready !== chain) begin
      bad++;
      $display("FAIL done_pulse got done=%b in_ready=%b want 0 %b", m_done, m_in_ready, chain);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      @(negedge clk);
      total++;
      if (m_busy !== 1'b0 || m_in_ready !== 1'b0 || m_q_valid !== 1'b0 || m_q_res !== 5'd0 ||
          m_q_data !== 32'd0 || m_out_valid !== 1'b0 || m_out_res !== 5'd0 || m_err !== 64'd0 ||
          m_out_max !== 32'd0 || m_done !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d got busy=%b rdy=%b qv=%b ov=%b err=%h done=%b want all 0",
                 s, m_busy, m_in_ready, m_q_valid, m_out_valid, m_err, m_done);
      end
    end
    sel = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (m_in_ready !== 1'b0 || m_busy !== 1'b0 || m_q_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_ignore got in_ready=%b busy=%b q_valid=%b want 0 0 0", m_in_ready, m_busy, m_q_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single;
    samp[0] = 32'h1234_5678;
    run_block(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_all_ones;
    for (int i = 0; i < 16; i++) samp[i] = 32'hFFFF_FFFF;
    run_block(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 4; i++) samp[i] = 32'hFFFF_FFFF;
    run_block(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) samp[i] = $urandom | 32'hC000_0000;
    run_block(2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) samp[i] = (i % 3 == 0) ? ($urandom & 32'h0001_FFFF) : $urandom;
    run_block(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_maxerr;
    samp[0] = 32'h0000_1234;
    samp[1] = 32'h0000_FFFF;
    for (int i = 2; i < 16; i++) samp[i] = $urandom & 32'h0000_0FFF;
    run_block(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midquant;
    sel = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = $urandom;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (m_q_valid !== 1'b1 || m_q_res !== 5'd4) begin
      bad++;
      $display("FAIL third_quant got q_valid=%b q_res=%0d want 1 4", m_q_valid, m_q_res);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (m_busy !== 1'b0 || m_in_ready !== 1'b0 || m_q_valid !== 1'b0 || m_q_res !== 5'd0 ||
        m_q_data !== 32'd0 || m_out_valid !== 1'b0 || m_err !== 64'd0 || m_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got busy=%b qv=%b qres=%0d qdata=%h ov=%b done=%b want all 0",
               m_busy, m_q_valid, m_q_res, m_q_data, m_out_valid, m_done);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) samp[i] = $urandom;
    run_block(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) samp[i] = $urandom;
    run_block(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) samp[i] = $urandom >> $urandom_range(0, 31);
    run_block(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_ones;
    test_saturation;
    test_random;
    test_maxerr;
    test_reset_midquant;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quant_sweep_ctrl.md
# quant_sweep_ctrl

Sequencer that pushes a block of 32-bit samples through the truncating quantizer family at resolutions 16, 8, 4, 3, 2 and 1 bits. It accumulates the truncation error for each resolution over the block, then reports the six totals over a ready/valid handshake. It sits between the sample source and the SQNR/results logic in the quantization lab datapath. It also provides a per-cycle monitor of each quantized value.

## Interface
Parameters:
- NUM_SAMPLES, 16, samples per block (1..2^16).
- ACC_W, 40, error accumulator width (32..64).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle block start; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  sample valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  32  unsigned sample Y.
- q_valid  out  1  high during each QUANT cycle.
- q_res  out  5  resolution currently applied (16, 8, 4, 3, 2 or 1).
- q_data  out  32  Y_hat = Y[31:32-q_res] followed by (32-q_res) zeros.
- out_valid  out  1  result valid (REPORT).
- out_ready  in  1  result consumer ready.
- out_res  out  5  resolution of the current result.
- out_err  out  ACC_W  accumulated error for out_res.
- out_max  out  32  maximum single-sample error for out_res (see Configuration).
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- States: IDLE, LOAD, QUANT, REPORT.
- Resolution index idx runs 0..5 and maps to 16, 8, 4, 3, 2, 1.
- Per-sample error is Y & ((1<<(32-r))-1), i.e. Y - Y_hat. It is unsigned and zero-extended to ACC_W.
- IDLE -> LOAD on start.
  - All six accumulators, all six max registers and the sample counter clear on that same edge.
- LOAD: in_ready=1. On in_valid&in_ready:
  - capture in_data;
  - increment the sample counter;
  - set idx=0;
  - go to QUANT.
- QUANT: one resolution per cycle.
  - q_valid=1; q_res and q_data reflect idx and the captured sample.
  - acc[idx] += err on the clock edge.
  - Addition saturates: if the true sum is ≥ 2^ACC_W, acc holds all-ones.
  - After idx=5: go to REPORT if counter == NUM_SAMPLES, else go to LOAD.
- REPORT: out_valid=1, presenting idx (starting at 0) with out_res, out_err and out_max.
  - idx advances on out_valid&out_ready.
  - Acceptance at idx=5 -> IDLE with done=1 for one cycle.
- start outside IDLE is ignored.
- in_valid outside LOAD is not accepted and in_data is ignored.

## Timing
- Reset values: busy=0, in_ready=0, q_valid=0, q_res=0, q_data=0, out_valid=0, out_res=0, out_err=0, out_max=0, done=0. State is IDLE, all accumulators, max registers and the counter are 0.
- rst overrides everything, including mid-QUANT and mid-REPORT. Partial results are discarded and no done pulse is issued.
- Start-to-LOAD latency: 1 cycle.
- Per sample: 1 accept cycle plus 6 QUANT cycles. Minimum throughput is 7 cycles per sample with in_valid held high.
- REPORT: minimum 6 cycles with out_ready held high.
  - out_* outputs stay stable while out_valid&!out_ready.
  - out_valid is never dropped before acceptance.
- q_* and out_* outputs are registered.
- done is asserted in the first IDLE cycle. A start in that same cycle is honoured.

## Configuration
- QSWEEP_MAXERR_EN defined:
  - six 32-bit max registers are kept;
  - in each QUANT cycle, max[idx] = max(max[idx], err);
  - out_max presents max[idx] in REPORT.
- Undefined:
  - the max registers and comparators are not built;
  - out_max is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- NUM_SAMPLES=1, Y=0x12345678:
  - q_data sequence 0x12340000, 0x12000000, 0x10000000, 0, 0, 0;
  - out_err sequence 0x5678, 0x345678, 0x2345678, 0x12345678, 0x12345678, 0x12345678;
  - done one cycle after the 6th acceptance.
- NUM_SAMPLES=16, Y=0xFFFFFFFF each sample, in_valid held high:
  - r16 err 0xFFFF0, r8 err 0xFFFFFF0, r1 err 0x7FFFFFFF0;
  - 112 cycles from LOAD entry to REPORT entry.
- ACC_W=32, NUM_SAMPLES=4, Y=0xFFFFFFFF:
  - r1 accumulator reaches 0xFFFFFFFE after 2 samples;
  - it saturates at 0xFFFFFFFF after samples 3 and 4;
  - r16 err is 0x3FFFC.
- REPORT with out_ready toggling 0/1:
  - each result is held stable while unaccepted;
  - exactly 6 results appear, in order 16, 8, 4, 3, 2, 1.
- Control robustness:
  - start pulsed during QUANT is ignored;
  - in_valid during QUANT is not accepted (in_ready=0);
  - rst asserted at the third QUANT cycle returns all outputs to 0 the next cycle;
  - a subsequent block produces clean totals.
- With QSWEEP_MAXERR_EN, samples 0x00001234 then 0x0000FFFF (NUM_SAMPLES=2):
  - r16 out_max is 0xFFFF;
  - r16 out_err is 0x11233.
- Without QSWEEP_MAXERR_EN, out_max stays 0.
